// File: rtl/vc_ctrl_param.sv
// vc_ctrl_param: per-input-VC control FSM for one (physical channel, VC) of
// the router input stage. Walks the head flit of this VC buffer through
// route latch (RC), VC/switch allocation (VSA) and switch traversal (ST).
//
// Ports:
//   clk, rst_            clock; asynchronous active-low reset
//   bdata, bvalid        head flit of this VC buffer and its valid
//   port, ovch           route / output VC for the current head flit
//   irdy_vec, ilck_vec   per (port,vc) downstream ready / locked-by-other
//   grt_vec              per-port switch grant to this VC
//   req, req_prio        switch request and its aged high-priority qualifier
//   send                 pop and forward bdata this cycle
//   olck, olck_vec       this VC holds an output VC; one-hot of which
//   err                  sticky packet-length watchdog error

`ifndef DATAW
`define DATAW 31
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif

module vc_ctrl_param #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int VCHID    = 0,
  parameter int NPORT    = 5,
  parameter int NVCH     = 2,
  parameter int DATAW    = `DATAW,
  parameter int AGEW     = 4,
  parameter int AGE_TH   = 8,
  parameter int MAXFLIT  = 16,
  localparam int PW      = (NPORT > 1) ? $clog2(NPORT) : 1,
  localparam int VW      = (NVCH > 1) ? $clog2(NVCH) : 1,
  localparam int SW      = NPORT * NVCH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   bdata,
  input  logic             bvalid,
  input  logic [PW-1:0]    port,
  input  logic [VW-1:0]    ovch,
  input  logic [SW-1:0]    irdy_vec,
  input  logic [SW-1:0]    ilck_vec,
  input  logic [NPORT-1:0] grt_vec,
  output logic             req,
  output logic             req_prio,
  output logic             send,
  output logic             olck,
  output logic [SW-1:0]    olck_vec,
  output logic             err
);

  localparam int FW = $clog2(MAXFLIT + 1);

  // Flit type encodings in bdata[`TYPE_MSB:`TYPE_LSB].
  localparam logic [1:0] FT_DATA = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HT   = 2'b11;

  typedef enum logic [1:0] {S_RC, S_VSA, S_ST} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   lport;
  logic [VW-1:0]   lovch;
  logic [AGEW-1:0] age;
  logic [FW-1:0]   fcnt;
  logic            req_r;

  logic [1:0]       ftype;
  logic             is_head, is_tail;
  logic [NPORT-1:0] port_oh;
  logic [SW-1:0]    sel_oh;
  logic             irdy_s, ilck_s, grt_s, alloc_ok;

  // Informational parameters and flit payload do not affect control.
  logic unused_ok;
  assign unused_ok = ^{bdata, FT_DATA, ((ROUTERID + PCHID + VCHID) != 0)};

  assign ftype   = bdata[`TYPE_MSB:`TYPE_LSB];
  assign is_head = (ftype == FT_HEAD) || (ftype == FT_HT);
  assign is_tail = (ftype == FT_TAIL) || (ftype == FT_HT);

  // One-hot decode of the latched route. An out-of-range lport/lovch
  // matches no bit, so every select reads 0 and the FSM parks in VSA.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign port_oh[p] = (lport == PW'(p));
    for (genvar v = 0; v < NVCH; v++) begin : g_vc
      assign sel_oh[p*NVCH+v] = port_oh[p] && (lovch == VW'(v));
    end
  end

  assign irdy_s   = |(irdy_vec & sel_oh);
  assign ilck_s   = |(ilck_vec & sel_oh);
  assign grt_s    = |(grt_vec & port_oh);
  // Lock beats grant: a locked output VC never lets us into ST.
  assign alloc_ok = grt_s && irdy_s && !ilck_s;

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= S_RC;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_RC:    if (bvalid && is_head) state_nx = S_VSA;
      S_VSA:   if (alloc_ok)          state_nx = S_ST;
      S_ST:    if (send && is_tail)   state_nx = S_RC;
      default:                        state_nx = S_RC;
    endcase
  end

  // Outputs
  always_comb begin
    send     = (state == S_ST) && bvalid && grt_s && irdy_s;
    olck     = (state != S_RC);
    req      = req_r && olck;
    req_prio = req && (32'(age) >= AGE_TH);
    olck_vec = olck ? sel_oh : '0;
  end

  // Route latch, age, flit count, request and watchdog
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      lport <= '0;
      lovch <= '0;
      age   <= '0;
      fcnt  <= '0;
      req_r <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_RC: if (bvalid && is_head) begin
          lport <= port;
          lovch <= ovch;
          age   <= '0;
          fcnt  <= '0;
          req_r <= 1'b1;
        end
        S_VSA: begin
          req_r <= !ilck_s;
          if (!alloc_ok && (age != {AGEW{1'b1}})) age <= age + 1'b1;
        end
        S_ST: if (send) begin
          if (fcnt != FW'(MAXFLIT)) fcnt <= fcnt + 1'b1;
          if (is_tail) begin
            req_r <= 1'b0;
            age   <= '0;
          end else if (fcnt == FW'(MAXFLIT - 1)) begin
            // Packet is about to exceed MAXFLIT; flag it but keep forwarding.
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_ctrl_param.sv
// Self-checking bench for vc_ctrl_param: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a packet-level model.
module tb_vc_ctrl_param;
  localparam int NPORT   = 5;
  localparam int NVCH    = 2;
  localparam int SW      = NPORT * NVCH;
  localparam int MAXFLIT = 4;
  localparam int AGE_TH  = 8;
  localparam int AGE_SAT = 15;
  localparam logic [1:0] T_DATA = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;
  localparam logic [SW-1:0]    ALL  = '1;
  localparam logic [NPORT-1:0] ALLG = '1;

  logic             clk = 1'b0;
  logic             rst_;
  logic [31:0]      bdata;
  logic             bvalid;
  logic [2:0]       port;
  logic [0:0]       ovch;
  logic [SW-1:0]    irdy_vec, ilck_vec;
  logic [NPORT-1:0] grt_vec;
  logic             req, req_prio, send, olck, err;
  logic [SW-1:0]    olck_vec;

  int checks = 0, failures = 0, nsend = 0;

  // Model: where the packet is (0 idle, 1 allocating, 2 sending), its route,
  // wait age, flits sent, pending request and sticky error.
  int m_ph, m_lp, m_lv, m_age, m_cnt;
  bit m_req, m_err;

  vc_ctrl_param #(.NPORT(NPORT), .NVCH(NVCH), .DATAW(31), .AGEW(4),
                  .AGE_TH(AGE_TH), .MAXFLIT(MAXFLIT)) dut (
    .clk(clk), .rst_(rst_), .bdata(bdata), .bvalid(bvalid), .port(port),
    .ovch(ovch), .irdy_vec(irdy_vec), .ilck_vec(ilck_vec), .grt_vec(grt_vec),
    .req(req), .req_prio(req_prio), .send(send), .olck(olck),
    .olck_vec(olck_vec), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = 0; m_lp = 0; m_lv = 0; m_age = 0; m_cnt = 0; m_req = 0; m_err = 0;
  endfunction

  task automatic drv(input bit v, input logic [1:0] t, input int p, input int ov,
                     input logic [SW-1:0] rdy, input logic [SW-1:0] lck,
                     input logic [NPORT-1:0] g);
    bvalid = v; bdata = {t, 30'($urandom)}; port = 3'(p); ovch = 1'(ov);
    irdy_vec = rdy; ilck_vec = lck; grt_vec = g;
    #1;
  endtask

  task automatic idle();
    drv(0, T_DATA, 0, 0, ALL, '0, ALLG);
  endtask

  // Compare all outputs with the model, advance the model over the coming
  // clock edge, then move to just after that edge.
  task automatic tick(input string tag);
    int idx;
    bit rdy_s, lck_s, g_s, e_send, e_req, hd, tl;
    logic [SW-1:0] ev;
    idx = (m_lp < NPORT && m_lv < NVCH) ? m_lp * NVCH + m_lv : -1;
    rdy_s = 0; lck_s = 0; g_s = 0; ev = '0;
    if (idx >= 0) begin rdy_s = irdy_vec[idx]; lck_s = ilck_vec[idx]; end
    if (m_lp < NPORT) g_s = grt_vec[m_lp];
    if (m_ph != 0 && idx >= 0) ev[idx] = 1'b1;
    e_send = (m_ph == 2) && bvalid && g_s && rdy_s;
    e_req  = (m_ph != 0) && m_req;
    chk({tag, ".req"},      req,      e_req);
    chk({tag, ".req_prio"}, req_prio, e_req && (m_age >= AGE_TH));
    chk({tag, ".send"},     send,     e_send);
    chk({tag, ".olck"},     olck,     m_ph != 0);
    chk({tag, ".olck_vec"}, olck_vec, ev);
    chk({tag, ".err"},      err,      m_err);
    if (send === 1'b1) nsend++;
    hd = bvalid && (bdata[31:30] == T_HEAD || bdata[31:30] == T_HT);
    tl = (bdata[31:30] == T_TAIL || bdata[31:30] == T_HT);
    if (!rst_) model_reset();
    else case (m_ph)
      0: if (hd) begin
        m_lp = int'(port); m_lv = int'(ovch); m_age = 0; m_cnt = 0; m_req = 1; m_ph = 1;
      end
      1: if (g_s && rdy_s && !lck_s) begin m_ph = 2; m_req = 1; end
         else begin m_req = !lck_s; if (m_age < AGE_SAT) m_age++; end
      default: if (e_send) begin
        if (tl) begin m_ph = 0; m_req = 0; m_age = 0; end
        else if (m_cnt == MAXFLIT - 1) m_err = 1;
        if (m_cnt < MAXFLIT) m_cnt++;
      end
    endcase
    @(posedge clk); #1;
  endtask

  // Assert reset between clock edges, check outputs drop at once, release
  // one cycle later away from the edge.
  task automatic async_rst(input string tag);
    #2; rst_ = 1'b0; model_reset(); #1;
    chk({tag, ".req"}, req, 0);       chk({tag, ".req_prio"}, req_prio, 0);
    chk({tag, ".send"}, send, 0);     chk({tag, ".olck"}, olck, 0);
    chk({tag, ".olck_vec"}, olck_vec, 0); chk({tag, ".err"}, err, 0);
    @(posedge clk); #1; rst_ = 1'b1;
  endtask

  initial begin
    rst_ = 1'b0; model_reset(); idle();
    chk("reset.req", req, 0);   chk("reset.req_prio", req_prio, 0);
    chk("reset.send", send, 0); chk("reset.olck", olck, 0);
    chk("reset.olck_vec", olck_vec, 0); chk("reset.err", err, 0);
    @(posedge clk); #1; rst_ = 1'b1;

    // Single HEADTAIL to port 2 / vc 1 (olck_vec bit 5)
    drv(1, T_HT, 2, 1, ALL, '0, ALLG); chk("ht.c0.olck", olck, 0); tick("ht.c0");
    drv(1, T_HT, 2, 1, ALL, '0, ALLG); chk("ht.c1.req", req, 1);
    chk("ht.c1.vec", olck_vec, 10'h20); chk("ht.c1.send", send, 0); tick("ht.c1");
    drv(1, T_HT, 2, 1, ALL, '0, ALLG); chk("ht.c2.send", send, 1);
    chk("ht.c2.vec", olck_vec, 10'h20); tick("ht.c2");
    idle(); chk("ht.c3.olck", olck, 0); chk("ht.c3.req", req, 0); tick("ht.c3");

    // 4-flit packet with one ready stall after the head send
    nsend = 0;
    drv(1, T_HEAD, 1, 0, ALL, '0, ALLG); tick("p4.c0");
    drv(1, T_HEAD, 1, 0, ALL, '0, ALLG); chk("p4.c1.req", req, 1); tick("p4.c1");
    drv(1, T_HEAD, 1, 0, ALL, '0, ALLG); chk("p4.c2.send", send, 1); tick("p4.c2");
    drv(1, T_DATA, 1, 0, ALL & ~10'h004, '0, ALLG);
    chk("p4.stall.send", send, 0); chk("p4.stall.req", req, 1); tick("p4.c3");
    drv(1, T_DATA, 1, 0, ALL, '0, ALLG); chk("p4.c4.send", send, 1); tick("p4.c4");
    drv(1, T_DATA, 1, 0, ALL, '0, ALLG); chk("p4.c5.send", send, 1); tick("p4.c5");
    drv(1, T_TAIL, 1, 0, ALL, '0, ALLG); chk("p4.c6.send", send, 1);
    chk("p4.c6.olck", olck, 1); tick("p4.c6");
    idle(); chk("p4.c7.olck", olck, 0); chk("p4.nsend", nsend, 4); tick("p4.c7");

    // Output VC locked for three VSA cycles, then released
    drv(1, T_HT, 3, 0, ALL, '0, ALLG); tick("lk.c0");
    drv(1, T_HT, 3, 0, ALL, 10'h040, ALLG); tick("lk.c1");
    drv(1, T_HT, 3, 0, ALL, 10'h040, ALLG); chk("lk.c2.req", req, 0);
    chk("lk.c2.olck", olck, 1); tick("lk.c2");
    drv(1, T_HT, 3, 0, ALL, 10'h040, ALLG); chk("lk.c3.req", req, 0); tick("lk.c3");
    drv(1, T_HT, 3, 0, ALL, '0, '0); tick("lk.c4");
    drv(1, T_HT, 3, 0, ALL, '0, ALLG); chk("lk.c5.req", req, 1); tick("lk.c5");
    drv(1, T_HT, 3, 0, ALL, '0, ALLG); chk("lk.c6.send", send, 1); tick("lk.c6");
    idle(); chk("lk.c7.olck", olck, 0); tick("lk.c7");

    // Wait-age escalation: grant withheld for 10 VSA cycles
    drv(1, T_HT, 4, 1, ALL, '0, ALLG); tick("age.c0");
    for (int k = 1; k <= 10; k++) begin
      drv(1, T_HT, 4, 1, ALL, '0, '0);
      chk($sformatf("age.vsa%0d.prio", k), req_prio, k >= 9);
      tick($sformatf("age.vsa%0d", k));
    end
    drv(1, T_HT, 4, 1, ALL, '0, ALLG); chk("age.c11.prio", req_prio, 1); tick("age.c11");
    drv(1, T_HT, 4, 1, ALL, '0, ALLG); chk("age.st.send", send, 1);
    chk("age.st.prio", req_prio, 1); tick("age.st");
    idle(); chk("age.rc.prio", req_prio, 0); chk("age.rc.olck", olck, 0); tick("age.rc");

    // Watchdog: HEAD + 5 DATA with MAXFLIT=4, then TAIL
    drv(1, T_HEAD, 0, 0, ALL, '0, ALLG); tick("wd.c0");
    drv(1, T_HEAD, 0, 0, ALL, '0, ALLG); tick("wd.c1");
    drv(1, T_HEAD, 0, 0, ALL, '0, ALLG); chk("wd.head.send", send, 1); tick("wd.c2");
    for (int i = 1; i <= 5; i++) begin
      drv(1, T_DATA, 0, 0, ALL, '0, ALLG);
      chk($sformatf("wd.d%0d.err", i), err, i >= 4);
      chk($sformatf("wd.d%0d.send", i), send, 1);
      tick($sformatf("wd.d%0d", i));
    end
    drv(1, T_TAIL, 0, 0, ALL, '0, ALLG); chk("wd.tail.err", err, 1); tick("wd.tail");
    idle(); chk("wd.rc.err", err, 1); chk("wd.rc.olck", olck, 0); tick("wd.rc");

    // Asynchronous reset while stalled in ST, then a fresh head
    drv(1, T_HEAD, 2, 0, ALL, '0, ALLG); tick("ar.c0");
    drv(1, T_HEAD, 2, 0, ALL, '0, ALLG); tick("ar.c1");
    drv(1, T_HEAD, 2, 0, '0, '0, ALLG); chk("ar.st.olck", olck, 1);
    chk("ar.st.req", req, 1); chk("ar.st.send", send, 0);
    async_rst("ar.mid");
    drv(1, T_HT, 2, 0, ALL, '0, ALLG); chk("ar.rc.olck", olck, 0); tick("ar.r0");
    drv(1, T_HT, 2, 0, ALL, '0, ALLG); chk("ar.r1.req", req, 1);
    chk("ar.r1.vec", olck_vec, 10'h010); tick("ar.r1");
    drv(1, T_HT, 2, 0, ALL, '0, ALLG); chk("ar.r2.send", send, 1); tick("ar.r2");
    idle(); tick("ar.r3");

    // Out-of-range port: latched, selects read 0, parked in VSA
    drv(1, T_HEAD, 6, 1, ALL, '0, ALLG); tick("oor.c0");
    for (int i = 0; i < 3; i++) begin
      drv(1, T_HEAD, 6, 1, ALL, '0, ALLG);
      chk("oor.olck", olck, 1); chk("oor.vec", olck_vec, 0); chk("oor.send", send, 0);
      tick("oor");
    end
    idle(); async_rst("oor.rst");

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      bit v;
      int p;
      logic [SW-1:0] rdy, lck;
      logic [NPORT-1:0] g;
      v   = ($urandom_range(0, 3) != 0);
      p   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      rdy = ($urandom_range(0, 3) == 0) ? SW'($urandom) : ALL;
      lck = ($urandom_range(0, 3) == 0) ? SW'($urandom) : '0;
      g   = ($urandom_range(0, 3) == 0) ? NPORT'($urandom) : ALLG;
      drv(v, 2'($urandom), p, int'($urandom_range(0, 1)), rdy, lck, g);
      if ($urandom_range(0, 299) == 0) async_rst("rnd.rst");
      else tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vc_ctrl_param.md
# vc_ctrl_param

Parametrised per-input-virtual-channel control FSM for the router input stage, one instance per (physical channel, VC). It takes the head flit of its VC buffer through route latch, VC/switch allocation and switch traversal. It generalises the fixed 5-port / fixed-VC controller to NPORT ports and NVCH VCs with flattened status vectors. It adds a latched route, a per-flit combinational send, a wait-age priority escalation and a packet-length watchdog.

## Interface
- ROUTERID, default 0: router identifier, informational.
- PCHID, default 0: physical input channel of this instance.
- VCHID, default 0: VC index of this instance.
- NPORT, default 5: number of output ports.
- NVCH, default 2: VCs per port.
- DATAW, default `DATAW: flit MSB index; type field at bdata[`TYPE_MSB:`TYPE_LSB].
- AGEW, default 4: wait-age counter width.
- AGE_TH, default 8: age at/above which req_prio asserts.
- MAXFLIT, default 16: maximum flits per packet before watchdog error.
- clk input 1: single clock, all state on rising edge.
- rst_ input 1: reset, asynchronous, active-low.
- bdata input DATAW+1: head flit of this VC's input buffer.
- bvalid input 1: buffer non-empty; bdata is meaningful only when high.
- port input clog2(NPORT): routing result for the current head flit.
- ovch input clog2(NVCH): output VC selected for the current head flit.
- irdy_vec input NPORT*NVCH: bit p*NVCH+v set means downstream VC v of port p can accept a flit.
- ilck_vec input NPORT*NVCH: bit set means that output VC is locked by another input VC; this VC's own lock is masked upstream.
- grt_vec input NPORT: switch grant to this VC, per output port.
- req output 1: switch request.
- req_prio output 1: high-priority qualifier for req.
- send output 1: pop and forward bdata this cycle.
- olck output 1: this VC holds an output VC.
- olck_vec output NPORT*NVCH: one-hot of the held output VC, all zero when not holding.
- err output 1: sticky watchdog error.

## Operation
- State register holds RC, VSA and ST; encoding is free. Registers: state, lport, lovch, age (AGEW), fcnt (clog2(MAXFLIT+1)), req_r, err.
- Selects use the latched values only: irdy_s = irdy_vec[lport*NVCH+lovch], ilck_s = ilck_vec[…], grt_s = grt_vec[lport].
- RC:
  - If bvalid and type is HEAD or HEADTAIL: latch port to lport and ovch to lovch; set age=0, fcnt=0, req_r=1; go to VSA.
  - Any other flit type at RC is ignored (no pop, no state change).
- VSA:
  - req_r = !ilck_s, registered each cycle.
  - If grt_s && irdy_s && !ilck_s: go to ST with req_r=1.
  - Otherwise age increments, saturating at 2^AGEW-1.
- ST:
  - send = bvalid && grt_s && irdy_s, combinational.
  - On each send, fcnt increments, saturating.
  - On a send of TAIL or HEADTAIL: go to RC, req_r=0, age=0.
  - On a send of a non-tail flit when fcnt==MAXFLIT-1: set err=1. err stays set until reset; the FSM keeps running.
- Outputs:
  - send=0 in RC and VSA.
  - req = req_r && (state!=RC).
  - req_prio = req && (age >= AGE_TH).
  - olck = (state!=RC).
  - olck_vec = olck ? onehot(lport*NVCH+lovch) : 0.
- A port or ovch value out of range (port ≥ NPORT) is latched as given. All of its selects then read 0, so the FSM stalls in VSA. Bench checks only, no recovery.

## Timing
- Reset (async assert, sync-release use): state=RC, lport=0, lovch=0, age=0, fcnt=0, req_r=0, err=0. Outputs: req=0, req_prio=0, send=0, olck=0, olck_vec=0. A reset mid-packet drops the lock immediately, with no tail handshake.
- Head seen at RC in cycle 0 gives state=VSA, req=1 and olck=1 in cycle 1.
- Grant and ready in cycle 1 gives ST in cycle 2; the earliest send is cycle 2 (2-cycle head latency).
- Back-to-back body/tail flits send one per cycle while bvalid, grt_s and irdy_s all stay high.
- A tail sent in cycle n gives RC in n+1 with olck=0 and req=0. A new head may be latched in n+1, giving VSA in n+2.
- ilck_s and grt_s both high in VSA: the lock wins, with no transition and req_r=0 next cycle.
- irdy_s or bvalid dropping in ST stalls send with no state change; req stays 1.

## Test plan
- Single HEADTAIL, port=2, ovch=1, NVCH=2, all irdy/grt high. Required: req=1 in cycle 1, send=1 in cycle 2, olck_vec=0x20 in cycles 1–2, RC in cycle 3.
- 4-flit packet (HEAD, DATA, DATA, TAIL) with irdy_s low in the cycle after the first send. Required: exactly 4 send pulses, one stall cycle, olck drops the cycle after the TAIL send.
- VSA with ilck_s=1 for 3 cycles, then released. Required: req=0 while locked, req=1 the cycle after release, grant then gives ST.
- AGE_TH=8 with grt held low 10 cycles in VSA. Required: req_prio rises in the 9th VSA cycle (age=8) and clears on entry to RC.
- MAXFLIT=4 with HEAD followed by 5 DATA flits. Required: err=1 after the 4th non-tail send; err stays 1 after a later TAIL and until rst_ is asserted.
- rst_ asserted asynchronously mid-ST, between clock edges. Required: all outputs 0 immediately; the next head after release restarts at RC.
